// File: rtl/riscv_lsu_pkg.sv
// Purpose: shared load/store size encodings and LSU FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_lsu_pkg;

    // Access size encodings, also used by decoder_riscv.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Purpose: bundles the core-side request/response and memory-side bus of the LSU.
// Latency: n/a (wiring only).
// Backpressure: core is held by core_stall_o; memory completes with mem_ready_i.
// Signal directions in the names are as seen from the LSU (slave modport).
interface riscv_lsu_if;
    import riscv_lsu_pkg::*;

    // core side
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        fault_o;
    // memory side
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    // LSU view
    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, fault_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    // core + memory view
    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, fault_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

endinterface

// File: rtl/riscv_lsu_data_align.sv
// Purpose: byte-lane steering for stores, extraction/extension for loads, legality check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: size/we/addr_lo/wd/rd_word in; be/wd_rep/ld_data/illegal out.
module lsu_data_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wd_rep,
    output logic [31:0] ld_data,
    output logic        illegal
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0.
    assign shifted = rd_word >> {addr_lo, 3'b000};

    always_comb begin
        be      = 4'b0000;
        wd_rep  = 32'h0;
        ld_data = 32'h0;
        illegal = 1'b0;
        case (size)
            LDST_B: begin
                be      = 4'b0001 << addr_lo;
                wd_rep  = {4{wd[7:0]}};
                ld_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            LDST_BU: begin
                illegal = we;  // unsigned sizes only make sense for loads
                be      = 4'b0001 << addr_lo;
                wd_rep  = {4{wd[7:0]}};
                ld_data = {24'h0, shifted[7:0]};
            end
            LDST_H: begin
                illegal = addr_lo[0];
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                wd_rep  = {2{wd[15:0]}};
                ld_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            LDST_HU: begin
                illegal = we | addr_lo[0];
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                wd_rep  = {2{wd[15:0]}};
                ld_data = {16'h0, shifted[15:0]};
            end
            LDST_W: begin
                illegal = (addr_lo != 2'b00);
                be      = 4'b1111;
                wd_rep  = wd;
                ld_data = shifted;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Purpose: load/store unit; turns core data requests into aligned memory accesses.
// Latency: request cycle + >=1 BUSY cycle + DONE cycle (3 cycles minimum); faults take 2.
// Backpressure: core_stall_o holds the core until DONE; memory stalls via mem_ready_i.
// Ports: clk_i, rst_ni, bus (riscv_lsu_if.slave: core_* request/response, mem_* bus).
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    riscv_lsu_if.slave    bus
);

    lsu_state_t  state_q;
    logic [31:0] rd_q;
    logic        fault_q;

    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [31:0] ld_data;
    logic        illegal;
    logic        mem_req;

    lsu_data_align u_align (
        .size    (bus.core_size_i),
        .we      (bus.core_we_i),
        .addr_lo (bus.core_addr_i[1:0]),
        .wd      (bus.core_wd_i),
        .rd_word (bus.mem_rd_i),
        .be      (be),
        .wd_rep  (wd_rep),
        .ld_data (ld_data),
        .illegal (illegal)
    );

    // Outputs are gated with rst_ni so they drop to zero the instant reset asserts,
    // not at the next edge.
    assign mem_req = rst_ni & (((state_q == IDLE) & bus.core_req_i & ~illegal)
                               | (state_q == BUSY));

    assign bus.core_stall_o = bus.core_req_i & (state_q != DONE) & rst_ni;
    assign bus.core_rd_o    = rd_q;
    assign bus.fault_o      = fault_q;

    assign bus.mem_req_o  = mem_req;
    assign bus.mem_we_o   = mem_req & bus.core_we_i;
    assign bus.mem_be_o   = mem_req ? be : 4'b0000;
    assign bus.mem_wd_o   = mem_req ? wd_rep : 32'h0;
    assign bus.mem_addr_o = mem_req ? {bus.core_addr_i[31:2], 2'b00} : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rd_q    <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.core_req_i) begin
                        if (illegal) begin
                            // Trapped locally: skip memory, report in DONE.
                            state_q <= DONE;
                            fault_q <= 1'b1;
                            rd_q    <= 32'h0;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready_i) begin
                        state_q <= DONE;
                        if (!bus.core_we_i) begin
                            rd_q <= ld_data;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Purpose: directed bench for riscv_lsu with a transaction-level model and per-cycle compare.
// Latency: n/a.
// Backpressure: drives mem_ready_i with per-transaction latency.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_lsu_if bus ();

    riscv_lsu dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle
    logic        exp_stall, exp_req, exp_we, exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr, exp_rd;
    logic [31:0] m_rd = 32'h0;

    // observations accumulated per transaction
    int          stall_seen = 0;
    int          req_seen   = 0;
    logic [3:0]  seen_be    = 4'h0;
    logic [31:0] seen_wd    = 32'h0;
    logic [31:0] seen_addr  = 32'h0;
    logic        seen_we    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_legal(input bit we, input logic [2:0] size, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (size)
            LDST_B:  return 1'b1;
            LDST_BU: return !we;
            LDST_H:  return (off % 2) == 0;
            LDST_HU: return !we && (off % 2) == 0;
            LDST_W:  return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (size)
            LDST_B, LDST_BU: return 4'(1 << off);
            LDST_H, LDST_HU: return (off >= 2) ? 4'b1100 : 4'b0011;
            default:         return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B:  return (wd & 32'hFF) * 32'h0101_0101;
            LDST_H:  return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] word);
        int unsigned off = addr % 4;
        logic [31:0] v = word >> (8 * off);
        case (size)
            LDST_B:  begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
            LDST_BU: v = v & 32'hFF;
            LDST_H:  begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            LDST_HU: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    // ---------------- compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(bus.core_stall_o), 32'(exp_stall));
            chk("mem_req", 32'(bus.mem_req_o), 32'(exp_req));
            chk("mem_we", 32'(bus.mem_we_o), 32'(exp_we));
            chk("mem_be", 32'(bus.mem_be_o), 32'(exp_be));
            chk("mem_wd", bus.mem_wd_o, exp_wd);
            chk("mem_addr", bus.mem_addr_o, exp_addr);
            chk("core_rd", bus.core_rd_o, exp_rd);
            chk("fault", 32'(bus.fault_o), 32'(exp_fault));
            if (bus.core_stall_o) stall_seen++;
            if (bus.mem_req_o) begin
                req_seen++;
                seen_be   = bus.mem_be_o;
                seen_wd   = bus.mem_wd_o;
                seen_addr = bus.mem_addr_o;
                seen_we   = bus.mem_we_o;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic rq, input logic we_, input logic [3:0] be_,
                           input logic [31:0] wd_, input logic [31:0] addr_, input logic flt);
        exp_stall = st;  exp_req = rq;   exp_we = we_; exp_be = be_;
        exp_wd    = wd_; exp_addr = addr_; exp_fault = flt; exp_rd = m_rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.core_req_i  = 1'b0;
            bus.mem_ready_i = 1'b0;
            set_exp(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        end
    endtask

    // One core access; memory answers with mem_ready_i in cycle 'lat' after the request
    // (lat >= 1). rdy_always keeps mem_ready_i high in every cycle. Returns after the
    // DONE cycle has been compared.
    task automatic access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int lat,
                          input bit rdy_always);
        bit ok = m_legal(we, size, addr);
        int n_busy = ok ? lat : 0;
        stall_seen = 0;
        req_seen   = 0;
        for (int c = 0; c <= n_busy; c++) begin
            step();
            bus.core_req_i  = 1'b1;
            bus.core_we_i   = we;
            bus.core_size_i = size;
            bus.core_addr_i = addr;
            bus.core_wd_i   = wd;
            bus.mem_rd_i    = word;
            bus.mem_ready_i = rdy_always || (ok && c == lat);
            if (ok) set_exp(1, 1, we, m_be(size, addr), m_wd(size, wd), addr & ~32'h3, 0);
            else    set_exp(1, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        end
        step();
        if (!ok)     m_rd = 32'h0;
        else if (!we) m_rd = m_ld(size, addr, word);
        bus.mem_ready_i = rdy_always;
        set_exp(0, 0, 0, 4'h0, 32'h0, 32'h0, !ok);
        @(negedge clk);
        #1;
    endtask

    // ---------------- sequence ----------------
    initial begin
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h100;
        bus.core_wd_i   = 32'h0;
        bus.mem_rd_i    = 32'hFFFF_FFFF;
        bus.mem_ready_i = 1'b1;
        set_exp(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

        // reset state with a legal request pending
        #12;
        chk("rst_stall", 32'(bus.core_stall_o), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_rd", bus.core_rd_o, 32'h0);
        chk("rst_fault", 32'(bus.fault_o), 32'h0);

        step();
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // LW, memory ready in cycle 3
        access(0, LDST_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 0);
        chk("lw_rd", bus.core_rd_o, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(stall_seen), 32'd4);
        chk("lw_be", 32'(seen_be), 32'hF);
        chk("lw_addr", seen_addr, 32'h100);

        access(0, LDST_B, 32'h103, 32'h0, 32'h80FF_0011, 1, 0);
        chk("lb_rd", bus.core_rd_o, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(stall_seen), 32'd2);
        access(0, LDST_BU, 32'h103, 32'h0, 32'h80FF_0011, 1, 0);
        chk("lbu_rd", bus.core_rd_o, 32'h0000_0080);
        access(0, LDST_HU, 32'h102, 32'h0, 32'h80FF_0011, 2, 0);
        chk("lhu_rd", bus.core_rd_o, 32'h0000_80FF);

        // stores leave core_rd_o untouched
        access(1, LDST_B, 32'h201, 32'h0000_00AB, 32'h0, 1, 0);
        chk("sb_be", 32'(seen_be), 32'h2);
        chk("sb_wd", seen_wd, 32'hABAB_ABAB);
        chk("sb_we", 32'(seen_we), 32'h1);
        chk("sb_rd_kept", bus.core_rd_o, 32'h0000_80FF);
        access(1, LDST_H, 32'h202, 32'h1234_CDEF, 32'h0, 1, 0);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wd", seen_wd, 32'hCDEF_CDEF);
        access(1, LDST_W, 32'h204, 32'h0BAD_F00D, 32'h0, 2, 0);

        access(0, LDST_H, 32'h102, 32'h0, 32'h80FF_0011, 1, 0);
        chk("lh_rd", bus.core_rd_o, 32'hFFFF_80FF);
        access(0, LDST_B, 32'h100, 32'h0, 32'h80FF_0011, 1, 0);
        chk("lb0_rd", bus.core_rd_o, 32'h0000_0011);

        // faults
        access(0, LDST_W, 32'h102, 32'h0, 32'h1234_5678, 1, 0);
        chk("lw_mis_fault", 32'(bus.fault_o), 32'h1);
        chk("lw_mis_req", 32'(req_seen), 32'd0);
        chk("lw_mis_stall", 32'(stall_seen), 32'd1);
        chk("lw_mis_rd", bus.core_rd_o, 32'h0);
        idle(1);
        access(1, LDST_H, 32'h001, 32'hFFFF, 32'h0, 1, 0);
        chk("sh_mis_req", 32'(req_seen), 32'd0);
        chk("sh_mis_stall", 32'(stall_seen), 32'd1);
        access(0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 0);
        chk("size3_req", 32'(req_seen), 32'd0);
        chk("size3_fault", 32'(bus.fault_o), 32'h1);
        access(1, LDST_BU, 32'h200, 32'h55, 32'h0, 1, 0);
        chk("sbu_req", 32'(req_seen), 32'd0);
        access(0, LDST_H, 32'h000, 32'h0, 32'h0000_7FFF, 1, 0);
        chk("lh_pos_rd", bus.core_rd_o, 32'h0000_7FFF);
        idle(1);

        // back-to-back loads, memory always ready
        access(0, LDST_W, 32'h300, 32'h0, 32'h1111_1111, 1, 1);
        chk("b2b_rd1", bus.core_rd_o, 32'h1111_1111);
        chk("b2b_stall1", 32'(stall_seen), 32'd2);
        access(0, LDST_W, 32'h304, 32'h0, 32'h2222_2222, 1, 1);
        chk("b2b_rd2", bus.core_rd_o, 32'h2222_2222);
        chk("b2b_stall2", 32'(stall_seen), 32'd2);
        idle(1);

        // reset asserted while BUSY
        step();
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h400;
        bus.mem_rd_i    = 32'h5A5A_5A5A;
        bus.mem_ready_i = 1'b0;
        set_exp(1, 1, 0, 4'hF, 32'h0, 32'h400, 0);
        step();
        #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.core_stall_o), 32'h0);
        chk("arst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("arst_mem_be", 32'(bus.mem_be_o), 32'h0);
        chk("arst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("arst_rd", bus.core_rd_o, 32'h0);
        chk("arst_fault", 32'(bus.fault_o), 32'h0);
        step();
        bus.core_req_i = 1'b0;
        rst_n = 1'b1;
        m_rd  = 32'h0;
        set_exp(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk_en = 1'b1;
        idle(1);
        @(negedge clk);
        #1;
        chk("post_rst_stall", 32'(bus.core_stall_o), 32'h0);
        access(0, LDST_W, 32'h500, 32'h0, 32'hCAFE_0001, 1, 0);
        chk("post_rst_rd", bus.core_rd_o, 32'hCAFE_0001);
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
